pipe_hazard_ctrl: RTL

Central sequencer for the five-stage integer pipeline. It drives the write enables of the PC and the FD/DE/EM/MW stage registers, plus per-stage bubble (flush) requests, to handle:
- load-use hazards,
- control redirects resolved in MEM,
- data-memory wait states,
- a debug halt/single-step port.

It sits beside the datapath in the CPU top level and owns no datapath state itself.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 6 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline-control state encoding and register-file constants
package pipe_hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG = 0;
  typedef enum logic [1:0] {RUN = 2'd0, DMEM_WAIT = 2'd1, HALTED = 2'd2} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: combinational load-use compare between the FD sources and the DE load target
module pipe_hazard_ctrl_hazard_detect #(
  parameter int REG_ADDR_W = pipe_hazard_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_use_rs,
  input  logic                  fd_use_rt,
  input  logic                  de_mem_read,
  input  logic [REG_ADDR_W-1:0] de_dst_reg,
  output logic                  hazard
);
  import pipe_hazard_ctrl_pkg::*;
  assign hazard = de_mem_read && de_dst_reg != REG_ADDR_W'(ZERO_REG) &&
                  ((fd_use_rs && fd_rs == de_dst_reg) || (fd_use_rt && fd_rt == de_dst_reg));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enable/flush sequencer for load-use, redirect, dmem wait and debug halt.
// Optional perf counters built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = pipe_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_use_rs,
  input  logic                  fd_use_rt,
  input  logic                  de_mem_read,
  input  logic [REG_ADDR_W-1:0] de_dst_reg,
  input  logic                  mem_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  dbg_halt,
  input  logic                  dbg_step,
  output logic                  pc_wren,
  output logic                  fd_wren,
  output logic                  de_wren,
  output logic                  em_wren,
  output logic                  mw_wren,
  output logic                  pc_sel_redirect,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic                  em_flush,
  output logic                  mw_flush,
  output logic                  halted,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
);
  import pipe_hazard_ctrl_pkg::*;
  state_t r_state, w_next;
  logic w_hazard, w_dwait, w_idle, w_redir, w_lu, w_hstop, w_pc_hold;
  pipe_hazard_ctrl_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hd (
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt),
    .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg), .hazard(w_hazard)
  );
  // A step from HALTED runs one full RUN evaluation except the halt rule itself
  always_comb begin
    w_dwait   = r_state == DMEM_WAIT ? !dmem_ready
                                     : (r_state == RUN || dbg_step) && dmem_req && !dmem_ready;
    w_idle    = r_state == HALTED && !dbg_step;
    w_redir   = !w_idle && !w_dwait && mem_redirect;
    w_lu      = !w_idle && !w_dwait && !mem_redirect && w_hazard;
    w_hstop   = w_idle || (r_state != HALTED && !w_dwait && !mem_redirect && !w_hazard && dbg_halt);
    w_pc_hold = w_dwait || w_lu || w_hstop;
    w_next    = w_dwait ? DMEM_WAIT : dbg_halt ? HALTED : RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= RUN;
    else r_state <= w_next;
  assign pc_wren         = !reset && !w_pc_hold;
  assign fd_wren         = !reset && !w_pc_hold;
  assign de_wren         = !reset && !w_dwait && !w_hstop;
  assign em_wren         = !reset && !w_dwait && !w_hstop;
  assign mw_wren         = !reset && !w_hstop;
  assign pc_sel_redirect = !reset && w_redir;
  assign fd_flush        = !reset && w_redir;
  assign de_flush        = !reset && (w_redir || w_lu);
  assign em_flush        = !reset && w_redir;
  assign mw_flush        = !reset && w_dwait;
  assign halted          = !reset && r_state == HALTED;
`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_hold && r_state != HALTED) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redir) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
